cmem_seq: RTL and testbench
===========================

Name: cmem_seq

Overview:
- Initiator/controller for the banked coefficient memory `cmem` in the FIR core. `cmem` has 8 read ports, a shared write port, and active-low CEN/WEN.
- Load phase: accepts a valid/ready coefficient stream and writes it sequentially across all banks.
- Read phase: sweeps all tap offsets, presenting one address per bank port per cycle, and flags the returned Q data as valid with a tap index.
- Sits between the host/config path and `cmem`; replaces ad-hoc driving of the memory pins.

Parameters:
- DW, 16, coefficient data width (matches `cmem` D/Q).
- AW, 8, per-port read address width.
- NBLK, 8, number of banks / read ports.
- DEPTH, 64, entries per bank; must be a power of 2 and ≤ 2**AW.
- Derived (localparam): BW = $clog2(NBLK), OW = $clog2(DEPTH), WAW = BW+OW.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- load_start  in  1  pulse: begin coefficient load
- rd_start  in  1  pulse: begin read sweep
- s_valid  in  1  coefficient word valid
- s_data  in  DW  coefficient word
- s_ready  out  1  controller accepts s_data this cycle
- cmem_cen  out  1  memory chip enable, active-low
- cmem_wen  out  1  memory write enable, active-low
- cmem_d  out  DW  memory write data
- cmem_wa  out  WAW  write address {bank, offset}
- cmem_a  out  NBLK*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_valid  out  1  cmem Q outputs hold valid data this cycle
- rd_tap  out  OW  tap offset of the data flagged by rd_valid
- busy  out  1  state != IDLE
- load_done  out  1  one-cycle pulse: load complete
- rd_done  out  1  one-cycle pulse: read sweep complete

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-high.
  - All state and outputs are registered.
- Reset values:
  - cmem_cen=1, cmem_wen=1, cmem_d=0, cmem_wa=0, cmem_a=0.
  - s_ready=0, rd_valid=0, rd_tap=0, busy=0, load_done=0, rd_done=0.
  - Counters=0, state=IDLE.
- States: IDLE, LOAD, READ.
- IDLE:
  - cen=1, wen=1, s_ready=0.
  - load_start → LOAD, with bank=0 and offset=0.
  - Otherwise rd_start → READ, with offset=0.
  - If both are asserted in the same cycle, load wins.
  - Start pulses outside IDLE are ignored.
- LOAD:
  - s_ready=1 combinationally while in LOAD.
  - Handshake (s_valid & s_ready) in cycle n → in cycle n+1: cen=0, wen=0, cmem_d=s_data, cmem_wa={bank,offset}.
  - Each handshake then increments offset. Offset wraps DEPTH-1 → 0 and increments bank.
  - A cycle without a handshake → in the next cycle: cen=1, wen=1. cmem_d and cmem_wa hold; counters hold.
  - On the NBLK*DEPTH-th handshake: state → IDLE. In the next cycle (the cycle of the final write), load_done=1 and busy=0.
- READ:
  - Each cycle issues one read: cen=0, wen=1, and every cmem_a port = offset (zero-extended to AW). Reads begin in the cycle after rd_start is accepted.
  - offset increments by 1 per cycle. After issuing offset DEPTH-1 → IDLE; cen returns to 1 in the following cycle.
  - Memory read latency is 1 cycle. rd_valid=1 and rd_tap=offset exactly one cycle after that offset's address is presented.
  - rd_done=1 in the same cycle as rd_valid for tap DEPTH-1.
- Write/read exclusivity: writes and reads are never issued in the same cycle, and wen=0 only occurs with cen=0.
- Reset mid-operation:
  - Abort immediately and return to IDLE with reset values.
  - No done pulse is generated.
  - Partial memory contents are not rolled back.
  - The next load restarts at wa=0.
- Width rules:
  - Counters are unsigned, with natural wrap at OW / BW bits.
  - No arithmetic is performed on data; s_data passes through unmodified.

Test Plan:
1. Assert rst for 3 cycles, with load_start/rd_start toggling → all outputs hold their reset values, busy=0, no memory activity.
2. load_start, then 512 back-to-back words with s_data=i → writes land at cmem_wa=i with cmem_d=i. Bank changes at i=64,128,… load_done pulses once, in the cycle of the write to wa=511.
3. Load with s_valid deasserted on every 3rd cycle → cen/wen high in each gap cycle, no address skips, exactly 512 writes, last wa=511.
4. rd_start after load → 64 consecutive cycles with cen=0, wen=1, all 8 ports = 0..63. rd_valid follows each address by exactly 1 cycle, rd_tap=0..63, rd_done coincides with rd_tap=63, busy drops.
5. load_start and rd_start in the same IDLE cycle → LOAD entered. rd_start pulsed during LOAD → ignored; no read cycles occur.
6. rst asserted after 100 accepted words → IDLE next cycle, no load_done. A new load_start → first write at cmem_wa=0.

Source files
------------

// File: rtl/cmem_seq.sv
// Load/read sequencer for the banked FIR coefficient memory.
// Writes a coefficient stream across all banks, then sweeps taps on all read ports.
module cmem_seq #(
    parameter int DW    = 16,
    parameter int AW    = 8,
    parameter int NBLK  = 8,
    parameter int DEPTH = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     load_start,
    input  logic                                     rd_start,
    input  logic                                     s_valid,
    input  logic [DW-1:0]                            s_data,
    output logic                                     s_ready,
    output logic                                     cmem_cen,
    output logic                                     cmem_wen,
    output logic [DW-1:0]                            cmem_d,
    output logic [$clog2(NBLK)+$clog2(DEPTH)-1:0]    cmem_wa,
    output logic [NBLK*AW-1:0]                       cmem_a,
    output logic                                     rd_valid,
    output logic [$clog2(DEPTH)-1:0]                 rd_tap,
    output logic                                     busy,
    output logic                                     load_done,
    output logic                                     rd_done
);

    localparam int BW  = $clog2(NBLK);
    localparam int OW  = $clog2(DEPTH);
    localparam int WAW = BW + OW;

    localparam logic [BW-1:0] BANK_MAX = BW'(NBLK - 1);
    localparam logic [OW-1:0] OFF_MAX  = OW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ
    } state_e;

    state_e            state_q;
    logic [BW-1:0]     bank_q;
    logic [OW-1:0]     off_q;
    logic              cen_q;
    logic              wen_q;
    logic [DW-1:0]     d_q;
    logic [WAW-1:0]    wa_q;
    logic [NBLK*AW-1:0] a_q;
    logic              rd_valid_q;
    logic [OW-1:0]     rd_tap_q;
    logic              load_done_q;
    logic              rd_done_q;

    logic              rd_issued;
    logic [OW-1:0]     a_tap;
    logic [AW-1:0]     rd_addr;

    // A read is on the pins this cycle; its Q is valid next cycle.
    assign rd_issued = !cen_q && wen_q;
    assign a_tap     = a_q[OW-1:0];
    assign rd_addr   = AW'(off_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            off_q       <= '0;
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
            d_q         <= '0;
            wa_q        <= '0;
            a_q         <= '0;
            rd_valid_q  <= 1'b0;
            rd_tap_q    <= '0;
            load_done_q <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
            load_done_q <= 1'b0;
            rd_valid_q  <= rd_issued;
            rd_done_q   <= rd_issued && (a_tap == OFF_MAX);
            if (rd_issued) begin
                rd_tap_q <= a_tap;
            end
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q <= LOAD;
                        bank_q  <= '0;
                        off_q   <= '0;
                    end else if (rd_start) begin
                        // Tap 0 goes out right away; the sweep continues from 1.
                        state_q <= READ;
                        cen_q   <= 1'b0;
                        a_q     <= '0;
                        off_q   <= OW'(1);
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        cen_q <= 1'b0;
                        wen_q <= 1'b0;
                        d_q   <= s_data;
                        wa_q  <= {bank_q, off_q};
                        off_q <= off_q + 1'b1;
                        if (off_q == OFF_MAX) begin
                            bank_q <= bank_q + 1'b1;
                            if (bank_q == BANK_MAX) begin
                                state_q     <= IDLE;
                                load_done_q <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    cen_q <= 1'b0;
                    a_q   <= {NBLK{rd_addr}};
                    off_q <= off_q + 1'b1;
                    if (off_q == OFF_MAX) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign cmem_cen  = cen_q;
    assign cmem_wen  = wen_q;
    assign cmem_d    = d_q;
    assign cmem_wa   = wa_q;
    assign cmem_a    = a_q;
    assign rd_valid  = rd_valid_q;
    assign rd_tap    = rd_tap_q;
    assign load_done = load_done_q;
    assign rd_done   = rd_done_q;

endmodule

// File: tb/tb_cmem_seq.sv
// Directed bench for cmem_seq with a write/read/tap scoreboard.
// Expected memory traffic is queued as stimulus is driven and checked per cycle.
module tb_cmem_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        rd_start;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        cmem_cen;
    logic        cmem_wen;
    logic [15:0] cmem_d;
    logic [8:0]  cmem_wa;
    logic [63:0] cmem_a;
    logic        rd_valid;
    logic [5:0]  rd_tap;
    logic        busy;
    logic        load_done;
    logic        rd_done;

    always #5 clk = ~clk;

    cmem_seq dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .rd_start   (rd_start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .cmem_cen   (cmem_cen),
        .cmem_wen   (cmem_wen),
        .cmem_d     (cmem_d),
        .cmem_wa    (cmem_wa),
        .cmem_a     (cmem_a),
        .rd_valid   (rd_valid),
        .rd_tap     (rd_tap),
        .busy       (busy),
        .load_done  (load_done),
        .rd_done    (rd_done)
    );

    typedef struct packed {
        logic [8:0]  wa;
        logic [15:0] d;
    } wr_t;

    int  pass_cnt = 0;
    int  total_cnt = 0;
    wr_t wq[$];
    int  aq[$];
    int  tq[$];
    int  mstate = 0;
    int  widx = 0;
    int  mroff = 0;
    int  nwr = 0;
    int  nrd = 0;
    int  ld_cnt = 0;
    int  rdd_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, advance the model, then check at the next negedge.
    task automatic step(input logic ls, input logic rs, input logic sv,
                        input logic [15:0] sd, input logic r);
        int         tap;
        wr_t        w;
        logic [7:0] t8;
        logic [63:0] ea;
        bit         ld_now;
        rst = r;
        load_start = ls;
        rd_start = rs;
        s_valid = sv;
        s_data = sd;
        ld_now = 0;
        if (r) begin
            mstate = 0;
            wq.delete();
            aq.delete();
            tq.delete();
        end else begin
            case (mstate)
                0: begin
                    if (ls) begin
                        mstate = 1;
                        widx = 0;
                    end else if (rs) begin
                        aq.push_back(0);
                        mroff = 1;
                        mstate = 2;
                    end
                end
                1: begin
                    if (sv) begin
                        w.wa = widx[8:0];
                        w.d = sd;
                        wq.push_back(w);
                        if (widx == 511) begin
                            mstate = 0;
                            ld_now = 1;
                        end
                        widx++;
                    end
                end
                default: begin
                    aq.push_back(mroff);
                    if (mroff == 63) mstate = 0;
                    mroff++;
                end
            endcase
        end
        @(negedge clk);
        chk("busy", busy, mstate != 0);
        chk("s_ready", s_ready, mstate == 1);
        chk("load_done", load_done, ld_now);
        if (load_done) ld_cnt++;
        chk("wen_without_cen", !cmem_wen && cmem_cen, 1'b0);
        if (tq.size() > 0) begin
            tap = tq.pop_front();
            chk("rd_valid", rd_valid, 1'b1);
            chk("rd_tap", rd_tap, tap[5:0]);
            chk("rd_done", rd_done, tap == 63);
            if (rd_done) rdd_cnt++;
        end else begin
            chk("rd_valid_idle", rd_valid, 1'b0);
            chk("rd_done_idle", rd_done, 1'b0);
        end
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("wr_cen", cmem_cen, 1'b0);
            chk("wr_wen", cmem_wen, 1'b0);
            chk("wr_wa", cmem_wa, w.wa);
            chk("wr_d", cmem_d, w.d);
            nwr++;
        end else if (aq.size() > 0) begin
            tap = aq.pop_front();
            t8 = tap[7:0];
            ea = {8{t8}};
            chk("rd_cen", cmem_cen, 1'b0);
            chk("rd_wen", cmem_wen, 1'b1);
            chk("rd_addr", cmem_a, ea);
            tq.push_back(tap);
            nrd++;
        end else begin
            chk("idle_cen", cmem_cen, 1'b1);
            chk("idle_wen", cmem_wen, 1'b1);
        end
    endtask

    initial begin
        int k;
        int c;
        rst = 1'b1;
        load_start = 1'b0;
        rd_start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        @(negedge clk);

        // Reset held with start pulses toggling.
        for (int i = 0; i < 3; i++) step(i[0], !i[0], 1'b1, 16'hFFFF, 1'b1);
        chk("rst_d", cmem_d, 16'h0);
        chk("rst_wa", cmem_wa, 9'h0);
        chk("rst_a", cmem_a, 64'h0);
        chk("rst_tap", rd_tap, 6'h0);
        step(0, 0, 0, 0, 0);

        // Back-to-back load of 512 words.
        nwr = 0;
        ld_cnt = 0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++) step(0, 0, 1, i[15:0], 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("load1_writes", nwr, 512);
        chk("load1_done_cnt", ld_cnt, 1);

        // Full read sweep.
        nrd = 0;
        rdd_cnt = 0;
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 70; i++) step(0, 0, 0, 0, 0);
        chk("read1_count", nrd, 64);
        chk("read1_done_cnt", rdd_cnt, 1);

        // Load with a gap on every third cycle.
        nwr = 0;
        ld_cnt = 0;
        k = 0;
        c = 0;
        step(1, 0, 0, 0, 0);
        while (k < 512 && c < 1000) begin
            if (c % 3 == 2) begin
                step(0, 0, 0, 16'hDEAD, 0);
            end else begin
                step(0, 0, 1, k[15:0] ^ 16'h5A5A, 0);
                k++;
            end
            c++;
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("load2_writes", nwr, 512);
        chk("load2_done_cnt", ld_cnt, 1);

        // Second sweep straight into a back-to-back restart.
        nrd = 0;
        rdd_cnt = 0;
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 62; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 70; i++) step(0, 0, 0, 0, 0);
        chk("read2_count", nrd, 128);
        chk("read2_done_cnt", rdd_cnt, 2);

        // Simultaneous starts, rd_start during load, then reset after 100 words.
        nwr = 0;
        ld_cnt = 0;
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(0, i == 50, 1, 16'h8000 | i[15:0], 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("abort_writes", nwr, 100);
        chk("abort_no_done", ld_cnt, 0);

        // Fresh load after abort restarts at address 0.
        nwr = 0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++) step(0, 0, 1, 16'h1234 + i[15:0], 0);
        step(0, 0, 0, 0, 0);
        chk("load3_writes", nwr, 512);
        chk("load3_done_cnt", ld_cnt, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
